muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//   Iterative RV32M multiply/divide unit; successor to the combinational ALU decoder.
//   It decodes funct3 for the M-extension and executes one operation over several cycles using a start/busy/done handshake.
//   It sits beside the main ALU in the execute stage. The controller stalls the pipeline while busy=1.
// PARAMETERS
//   XLEN         32  operand/result width in bits (even, >=4)
//   ZERO_BYPASS  1   1: a DIV/REM with b==0 finishes in 1 iteration cycle; 0: runs the full length
// PORTS
//   clk        in   1     rising-edge clock
//   reset      in   1     synchronous, active-high reset
//   start      in   1     request; sampled only in IDLE
//   funct3     in   3     000 mul,001 mulh,010 mulhsu,011 mulhu,100 div,101 divu,110 rem,111 remu
//   a          in   XLEN  rs1 operand, sampled with start
//   b          in   XLEN  rs2 operand, sampled with start
//   busy       out  1     operation in progress
//   done       out  1     one-cycle pulse; result is valid from this cycle
//   result     out  XLEN  result; held until the next accepted start
// BEHAVIOUR
//   Reset: state=IDLE; busy=0, done=0, result=0; internal regs cleared. Reset wins over start.
//   Reset while busy aborts the operation; no done pulse is produced for it.
//   States: IDLE -> RUN -> FIX -> IDLE.
//   IDLE: on an edge with start=1, do all of the following:
//     - latch funct3 and the operand sign flags;
//     - load |a| and |b| (magnitudes taken only for signed operands);
//     - set cnt=XLEN, busy<=1, go to RUN.
//   Signedness of a/b: mul, mulh, div, rem use signed/signed; mulhsu uses signed a, unsigned b; mulhu, divu, remu use unsigned/unsigned.
//   RUN, multiply: shift-add over a 2*XLEN accumulator, one multiplier bit per cycle.
//   RUN, divide: restoring divide, one quotient bit per cycle.
//   RUN: cnt decrements every cycle; when cnt reaches 1, go to FIX.
//   FIX (one cycle):
//     - apply sign correction: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign;
//     - register the result; done<=1, busy<=0; go to IDLE.
//   Latency: the start edge is E0; done is high after edge E(XLEN+1), i.e. XLEN+1 clocks. Throughput is one op per XLEN+2 clocks.
//   Result selection:
//     - mul returns the low XLEN bits;
//     - mulh, mulhsu, mulhu return the high XLEN bits;
//     - div, divu return the quotient; rem, remu return the remainder.
//   Divide by zero (no trap):
//     - quotient = all ones; remainder = a.
//     - With ZERO_BYPASS=1 it skips RUN iterations: done follows edge E2.
//   Signed overflow (a = most negative value, b = -1):
//     - div returns a, rem returns 0; the normal iteration count applies.
//   start while busy=1 or during FIX is ignored; operands are not re-sampled.
//   start in the same cycle as done (the unit is back in IDLE) is accepted.
//   done is exactly one cycle wide. result is stable between done and the next E0.
//   All arithmetic is modulo 2^XLEN (mul low half) or 2^(2*XLEN) (accumulator); no X on outputs after reset.
// TESTING
//   1. mul a=7, b=-3 (0xFFFFFFFD) -> result 0xFFFFFFEB; done exactly 33 clocks after start; busy high 33 cycles.
//   2. mulh/mulhsu/mulhu a=0x80000000, b=0xFFFFFFFF -> 0x00000000 / 0x80000000 / 0x7FFFFFFF.
//   3. div/rem a=-7, b=2 -> -3 (0xFFFFFFFD) / -1 (0xFFFFFFFF); divu a=100, b=7 -> 14; remu -> 2.
//   4. div a=5, b=0 -> 0xFFFFFFFF; rem -> 5; with ZERO_BYPASS=1 done 2 clocks after start; div 0x80000000 / -1 -> 0x80000000, rem -> 0.
//   5. start pulsed again mid-op with different a/b -> ignored; original result returned; back-to-back start on the done cycle accepted.
//   6. reset asserted at cycle 10 of a div -> next cycle busy=0, done=0, result=0; no done pulse follows; next op correct.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// start/busy/done handshake, one result bit per RUN cycle.
//
// state | meaning
// IDLE  | waiting for start; result held
// RUN   | one multiplier/quotient bit per cycle, cnt counts down
// FIX   | sign correction and result select; done pulses next cycle
module muldiv_unit #(
    parameter int XLEN        = 32,
    parameter bit ZERO_BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t                state_q,  state_d;
    logic [CW-1:0]         cnt_q,    cnt_d;
    logic [2:0]            op_q,     op_d;
    logic                  a_neg_q,  a_neg_d;
    logic                  b_neg_q,  b_neg_d;
    logic                  b_zero_q, b_zero_d;
    logic [XLEN-1:0]       a_q,      a_d;
    logic [XLEN-1:0]       mcand_q,  mcand_d;
    logic [2*XLEN-1:0]     acc_q,    acc_d;
    logic                  busy_q,   busy_d;
    logic                  done_q,   done_d;
    logic [XLEN-1:0]       result_q, result_d;

    logic                  sgn_a, sgn_b;
    logic                  a_neg_in, b_neg_in;
    logic [XLEN-1:0]       mag_a, mag_b;
    logic [XLEN:0]         mul_sum;
    logic [2*XLEN-1:0]     mul_next;
    logic [XLEN:0]         rem_sh, rem_diff;
    logic                  rem_ge;
    logic [2*XLEN-1:0]     div_next;
    logic [2*XLEN-1:0]     prod_fix;
    logic [XLEN-1:0]       quot_fix, rem_fix;
    logic [XLEN-1:0]       fix_result;

    always_comb begin
        case (funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin sgn_a = 1'b1; sgn_b = 1'b1; end
            3'b010:                         begin sgn_a = 1'b1; sgn_b = 1'b0; end
            default:                        begin sgn_a = 1'b0; sgn_b = 1'b0; end
        endcase
        a_neg_in = sgn_a & a[XLEN-1];
        b_neg_in = sgn_b & b[XLEN-1];
        mag_a    = a_neg_in ? -a : a;
        mag_b    = b_neg_in ? -b : b;
    end

    // Multiply: acc = {partial_hi, remaining multiplier bits}, shifted right each step.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
    end

    // Divide: acc = {partial remainder, dividend shifting out / quotient shifting in}.
    always_comb begin
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        rem_diff = rem_sh - {1'b0, mcand_q};
        rem_ge   = (rem_sh >= {1'b0, mcand_q});
        div_next = {(rem_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], rem_ge};
    end

    always_comb begin
        prod_fix = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
        quot_fix = (a_neg_q ^ b_neg_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = a_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        if (!op_q[2]) begin
            fix_result = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else if (!op_q[1]) begin
            fix_result = b_zero_q ? {XLEN{1'b1}} : quot_fix;
        end else begin
            fix_result = b_zero_q ? a_q : rem_fix;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        b_zero_d = b_zero_q;
        a_d      = a_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d     = funct3;
                    a_neg_d  = a_neg_in;
                    b_neg_d  = b_neg_in;
                    b_zero_d = (b == {XLEN{1'b0}});
                    a_d      = a;
                    if (funct3[2]) begin
                        mcand_d = mag_b;
                        acc_d   = {{XLEN{1'b0}}, mag_a};
                    end else begin
                        mcand_d = mag_a;
                        acc_d   = {{XLEN{1'b0}}, mag_b};
                    end
                    cnt_d   = CW'(XLEN);
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = op_q[2] ? div_next : mul_next;
                cnt_d = cnt_q - CW'(1);
                // A zero divisor result is forced in FIX, so the iterations can be skipped.
                if (cnt_q == CW'(1) || (ZERO_BYPASS && op_q[2] && b_zero_q)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = fix_result;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            a_q      <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            b_zero_q <= b_zero_d;
            a_q      <= a_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes expected result and latency,
// a negedge monitor pops and checks on every done pulse.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    muldiv_unit #(.XLEN(32), .ZERO_BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] res;
        int          e0;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                check("done_width", {31'd0, prev_done}, 32'd0);
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done at cycle %0d, expected no pending op", cyc);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_result"}, result, e.res);
                    check({e.name, "_latency"}, cyc - e.e0, e.lat);
                end
            end
            prev_done = done;
        end
    end

    // Called just after a negedge; start is seen by the next rising edge (E0).
    task automatic issue(input string name, input logic [2:0] f3, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] res, input int lat);
        exp_t e;
        start  = 1'b1;
        funct3 = f3;
        a      = av;
        b      = bv;
        e.name = name; e.res = res; e.e0 = cyc + 1; e.lat = lat;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int bcnt);
        int n;
        bcnt = 0;
        n    = 0;
        while (done !== 1'b1 && n < 80) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no done in 80 cycles, expected done", name);
        end
    endtask

    task automatic op(input string name, input logic [2:0] f3, input logic [31:0] av,
                      input logic [31:0] bv, input logic [31:0] res, input int lat);
        int bc;
        issue(name, f3, av, bv, res, lat);
        wait_done(name, bc);
    endtask

    initial begin
        int bc;
        reset  = 1'b1;
        start  = 1'b0;
        funct3 = 3'b000;
        a      = '0;
        b      = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        issue("mul_7_m3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        wait_done("mul_7_m3", bc);
        check("mul_busy_cycles", bc, 33);

        op("mulh",   3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        op("mulhsu", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        op("mulhu",  3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 33);
        op("mul_9",  3'b000, 32'h1234_5678, 32'd9,         32'hA3D7_0A38, 33);

        op("div_m7_2",  3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        op("rem_m7_2",  3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 33);
        op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 33);

        issue("div_5_0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
        wait_done("div_5_0", bc);
        check("div0_busy_cycles", bc, 2);
        op("rem_5_0",   3'b110, 32'd5,         32'd0, 32'd5,         2);
        op("divu_5_0",  3'b101, 32'd5,         32'd0, 32'hFFFF_FFFF, 2);
        op("rem_m5_0",  3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 2);
        op("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        op("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33);

        // Extra start pulses mid-RUN and during FIX must be ignored.
        issue("div_ignore", 3'b100, 32'd100, 32'd7, 32'd14, 33);
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            start  = (k == 5 || k == 32);
            funct3 = 3'b000;
            a      = 32'd1000;
            b      = 32'd3;
        end
        @(negedge clk);
        start = 1'b0;
        check("ignore_done_seen", {31'd0, done}, 32'd1);
        repeat (3) @(negedge clk);
        check("ignore_idle", {31'd0, busy}, 32'd0);

        // Back-to-back: second start issued in the done cycle.
        issue("b2b_mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        wait_done("b2b_mulhu", bc);
        issue("b2b_remu", 3'b111, 32'd100, 32'd7, 32'd2, 33);
        wait_done("b2b_remu", bc);

        // Reset at cycle 10 of a divide aborts it without a done pulse.
        @(negedge clk);
        issue("div_abort", 3'b101, 32'd1000, 32'd3, 32'd333, 33);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        void'(sb.pop_back());
        reset = 1'b0;
        repeat (40) @(negedge clk);
        op("divu_after_abort", 3'b101, 32'd1000, 32'd3, 32'd333, 33);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
